// File: rtl/nn_infer_seq_if.sv
// Stream-in / ROM-read / result-out signal bundle for nn_infer_seq.
// slave is the inference block, master is whatever drives and consumes it.
interface nn_infer_seq_if #(
    parameter int N_INPUTS  = 4,
    parameter int N_OUTPUTS = 3
);
    localparam int K  = N_INPUTS * N_OUTPUTS;
    localparam int AW = $clog2(K);
    localparam int PW = $clog2(N_OUTPUTS);

    logic                in_valid;
    logic                in_ready;
    logic signed [15:0]  in_data;
    logic                w_rd_en;
    logic [AW-1:0]       w_addr;
    logic signed [15:0]  w_data;
    logic                out_valid;
    logic                out_ready;
    logic [PW-1:0]       out_pred;
    logic signed [15:0]  out_max;
    logic                busy;

    modport slave (
        input  in_valid, in_data, w_data, out_ready,
        output in_ready, w_rd_en, w_addr, out_valid, out_pred, out_max, busy
    );

    modport master (
        output in_valid, in_data, w_data, out_ready,
        input  in_ready, w_rd_en, w_addr, out_valid, out_pred, out_max, busy
    );
endinterface

// File: rtl/nn_infer_seq.sv
// Sequential dense layer + ReLU + argmax: one MAC per cycle against an external
// synchronous weight ROM, input streamed in, predicted class returned by handshake.
module nn_infer_seq #(
    parameter int N_INPUTS  = 4,
    parameter int N_OUTPUTS = 3
) (
    input logic          clk,
    input logic          rst,
    nn_infer_seq_if.slave bus
);
    localparam int K  = N_INPUTS * N_OUTPUTS;
    localparam int AW = $clog2(K);
    localparam int IW = $clog2(N_INPUTS);
    localparam int PW = $clog2(N_OUTPUTS);
    localparam int KW = $clog2(K + 1);

    typedef enum logic [1:0] {StLoad, StMac, StDone} state_e;

    state_e              state_q, state_d;
    logic signed [15:0]  xbuf_q [N_INPUTS];
    logic [IW-1:0]       idx_q;
    logic [KW-1:0]       k_q;
    logic [IW-1:0]       i_q, ai_q;
    logic [PW-1:0]       j_q, aj_q;
    logic                rd_vld_q;
    logic signed [31:0]  acc_q, acc_d, prod;
    logic signed [15:0]  y, r;
    logic signed [15:0]  run_max_q, run_max_d, max_q;
    logic [PW-1:0]       run_pred_q, run_pred_d, pred_q;

    logic in_fire, last_in, issue, drain;

    assign in_fire = bus.in_valid && (state_q == StLoad) && !rst;
    assign last_in = (idx_q == IW'(N_INPUTS - 1));
    assign issue   = (state_q == StMac) && (k_q < KW'(K));
    assign drain   = (state_q == StMac) && (k_q == KW'(K));

    assign bus.w_addr   = AW'(32'(i_q) * N_OUTPUTS + 32'(j_q));
    assign bus.out_pred = pred_q;
    assign bus.out_max  = max_q;

    // Datapath for the read issued one cycle earlier; w_data is valid now.
    always_comb begin
        prod       = xbuf_q[ai_q] * bus.w_data;
        acc_d      = (ai_q == '0) ? prod : acc_q + prod;
        y          = acc_d[15:0];
        r          = (y > 0) ? y : '0;
        run_max_d  = run_max_q;
        run_pred_d = run_pred_q;
        if (rd_vld_q && (ai_q == IW'(N_INPUTS - 1)) && ((aj_q == '0) || (r > run_max_q))) begin
            run_max_d  = r;
            run_pred_d = aj_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.w_rd_en   = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            StLoad: begin
                bus.in_ready = !rst;
                if (in_fire && last_in) state_d = StMac;
            end
            StMac: begin
                bus.busy    = 1'b1;
                bus.w_rd_en = issue;
                if (drain) state_d = StDone;
            end
            StDone: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StLoad;
            for (int n = 0; n < N_INPUTS; n++) xbuf_q[n] <= '0;
            idx_q      <= '0;
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            ai_q       <= '0;
            aj_q       <= '0;
            rd_vld_q   <= 1'b0;
            acc_q      <= '0;
            run_max_q  <= '0;
            run_pred_q <= '0;
            max_q      <= '0;
            pred_q     <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                xbuf_q[idx_q] <= bus.in_data;
                idx_q         <= last_in ? '0 : idx_q + IW'(1);
                if (last_in) begin
                    k_q <= '0;
                    i_q <= '0;
                    j_q <= '0;
                end
            end
            // Issue order: j outer, i inner.
            if (issue) begin
                k_q <= k_q + KW'(1);
                if (i_q == IW'(N_INPUTS - 1)) begin
                    i_q <= '0;
                    j_q <= j_q + PW'(1);
                end else begin
                    i_q <= i_q + IW'(1);
                end
            end
            rd_vld_q <= issue;
            ai_q     <= i_q;
            aj_q     <= j_q;
            if (rd_vld_q) acc_q <= acc_d;
            run_max_q  <= run_max_d;
            run_pred_q <= run_pred_d;
            if (drain) begin
                max_q  <= run_max_d;
                pred_q <= run_pred_d;
            end
        end
    end
endmodule
